// File: rtl/onehot_dec_pkg.sv
// Shared definitions for the sequential one-hot decoder.
//   state_t   : FSM state encoding (IDLE / DRIVE / GAP)
//   cnt_width : width of the hold/gap counter for a given HOLD/GAP pair
package onehot_dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Counter must hold max(hold, gap); never narrower than one bit.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Code-input handshake bundle for onehot_decoder_seq.
//   in_valid : code present (master -> slave)
//   in_ready : slave can accept a code (slave -> master)
//   code     : binary line index, WIDTH bits (master -> slave)
//   code_par : even parity over code, only with ONEHOT_DECODER_PARITY_EN
interface onehot_decoder_seq_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] code;
`ifdef ONEHOT_DECODER_PARITY_EN
    logic             code_par;

    modport master (output in_valid, output code, output code_par, input in_ready);
    modport slave  (input in_valid, input code, input code_par, output in_ready);
`else
    modport master (output in_valid, output code, input in_ready);
    modport slave  (input in_valid, input code, output in_ready);
`endif
endinterface

// File: rtl/onehot_dec_core.sv
// Pure combinational binary-to-one-hot conversion.
//   code : WIDTH-bit line index
//   y    : 2**WIDTH-bit one-hot result, bit [code] set
module onehot_dec_core #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0]      code,
    output logic [2**WIDTH-1:0]   y
);

    always_comb begin
        y       = '0;
        y[code] = 1'b1;
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequential binary-to-one-hot decoder with a one-entry pending buffer.
// Each accepted code drives its one-hot line for HOLD_CYCLES cycles, followed
// by GAP_CYCLES all-zero cycles.
//   clk, rst : clock, synchronous active-high reset
//   en       : global enable; low aborts the current output, keeps pending
//   bus      : code handshake (in_valid / in_ready / code [/ code_par])
//   y        : registered one-hot output, zero when not driving
//   busy     : FSM active or pending entry held
//   done     : pulse on the last DRIVE cycle of each code
//   par_err  : pulse the cycle after a bad-parity transfer
// Optional: ONEHOT_DECODER_PARITY_EN adds code_par / par_err; bad-parity codes
// are consumed but discarded.
module onehot_decoder_seq
    import onehot_dec_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    onehot_decoder_seq_if.slave   bus,
    output logic [2**WIDTH-1:0]   y,
    output logic                  busy,
    output logic                  done
`ifdef ONEHOT_DECODER_PARITY_EN
    ,
    output logic                  par_err
`endif
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   cur_q, cur_d;
    logic               pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0]   pend_code_q, pend_code_d;
    logic [2**WIDTH-1:0] onehot, y_d;
    logic               done_d;
    logic               code_ok, accept, bypass, load_pend;
`ifdef ONEHOT_DECODER_PARITY_EN
    logic               par_err_d;
`endif

    // One-hot of the code that will be on y after this edge.
    onehot_dec_core #(.WIDTH(WIDTH)) u_core (
        .code (cur_d),
        .y    (onehot)
    );

    always_comb begin
`ifdef ONEHOT_DECODER_PARITY_EN
        code_ok = (bus.code_par == ^bus.code);
`else
        code_ok = 1'b1;
`endif
        accept = bus.in_valid && bus.in_ready && code_ok;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cur_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_code_q  <= '0;
            y            <= '0;
            done         <= 1'b0;
`ifdef ONEHOT_DECODER_PARITY_EN
            par_err      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            y            <= y_d;
            done         <= done_d;
`ifdef ONEHOT_DECODER_PARITY_EN
            par_err      <= par_err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_d        = cur_q;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        bypass       = 1'b0;
        load_pend    = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_valid_q)
                        load_pend = 1'b1;
                    else if (accept)
                        bypass = 1'b1;
                end
                DRIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end else if (pend_valid_q) begin
                        load_pend = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                GAP: begin
                    if (cnt_q != '0)
                        cnt_d = cnt_q - 1'b1;
                    else if (pend_valid_q)
                        load_pend = 1'b1;
                    else
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (load_pend) begin
            state_d      = DRIVE;
            cnt_d        = HOLD_LD;
            cur_d        = pend_code_q;
            pend_valid_d = 1'b0;
        end
        if (bypass) begin
            state_d = DRIVE;
            cnt_d   = HOLD_LD;
            cur_d   = bus.code;
        end
        // A transfer not taken straight into DRIVE lands in pending; this also
        // covers a transfer coinciding with pending being loaded.
        if (accept && !bypass) begin
            pend_valid_d = 1'b1;
            pend_code_d  = bus.code;
        end
    end

    // Outputs: handshake/status from current state, registered outputs from next state
    always_comb begin
        bus.in_ready = !rst && en && !pend_valid_q;
        busy         = !rst && ((state_q != IDLE) || pend_valid_q);
        y_d          = (state_d == DRIVE) ? onehot : '0;
        done_d       = (state_d == DRIVE) && (cnt_d == '0);
`ifdef ONEHOT_DECODER_PARITY_EN
        par_err_d    = bus.in_valid && bus.in_ready && !code_ok;
`endif
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: DUT A uses HOLD=4/GAP=1, DUT B uses HOLD=4/GAP=0.
// Both see the same stimulus; each is compared every cycle against a schedule
// model, plus table vectors and hand-written corner sequences.
// Builds with or without ONEHOT_DECODER_PARITY_EN.
module tb_onehot_decoder_seq;

    localparam int W = 3;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst, en, vld, bad;
    logic [W-1:0] cd;

    always #5 clk = ~clk;

    onehot_decoder_seq_if #(.WIDTH(W)) bus_a ();
    onehot_decoder_seq_if #(.WIDTH(W)) bus_b ();

    assign bus_a.in_valid = vld;
    assign bus_a.code     = cd;
    assign bus_b.in_valid = vld;
    assign bus_b.code     = cd;
`ifdef ONEHOT_DECODER_PARITY_EN
    assign bus_a.code_par = (^cd) ^ bad;
    assign bus_b.code_par = (^cd) ^ bad;
    logic perr_a, perr_b;
`endif

    logic [7:0] y_a, y_b;
    logic busy_a, busy_b, done_a, done_b;

    onehot_decoder_seq #(.WIDTH(W), .HOLD_CYCLES(H), .GAP_CYCLES(1)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .bus  (bus_a),
        .y    (y_a),
        .busy (busy_a),
        .done (done_a)
`ifdef ONEHOT_DECODER_PARITY_EN
        ,
        .par_err (perr_a)
`endif
    );

    onehot_decoder_seq #(.WIDTH(W), .HOLD_CYCLES(H), .GAP_CYCLES(0)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .bus  (bus_b),
        .y    (y_b),
        .busy (busy_b),
        .done (done_b)
`ifdef ONEHOT_DECODER_PARITY_EN
        ,
        .par_err (perr_b)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: each started code expands into a schedule of H+gap output
    // slots (H one-hot slots, then gap zero slots); 'left' counts unplayed slots.
    // wv/wcode is a code accepted but not yet started; idle marks an output slot
    // that came from no schedule.
    int   left[2], scode[2], wcode[2];
    bit   wv[2], idle[2];
    logic [7:0] ey[2];
    bit   edone[2], eperr[2];

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int  g, pos;
            bit  x, good, started;
            g        = gap_of(i);
            eperr[i] = 1'b0;
            if (rst) begin
                left[i] = 0; wv[i] = 1'b0; idle[i] = 1'b1; ey[i] = '0; edone[i] = 1'b0;
            end else if (!en) begin
                left[i] = 0; idle[i] = 1'b1; ey[i] = '0; edone[i] = 1'b0;
            end else begin
                x        = vld && !wv[i];
                good     = x && !bad;
                eperr[i] = x && bad;
                started  = 1'b0;
                if (left[i] == 0 && wv[i]) begin
                    scode[i] = wcode[i]; left[i] = H + g; wv[i] = 1'b0;
                end else if (left[i] == 0 && idle[i] && good) begin
                    scode[i] = int'(cd); left[i] = H + g; started = 1'b1;
                end
                if (good && !started) begin
                    wv[i] = 1'b1; wcode[i] = int'(cd);
                end
                if (left[i] > 0) begin
                    pos      = H + g - left[i];
                    ey[i]    = (pos < H) ? 8'(1 << scode[i]) : 8'h00;
                    edone[i] = (pos == H - 1);
                    left[i]--;
                    idle[i]  = 1'b0;
                end else begin
                    ey[i] = '0; edone[i] = 1'b0; idle[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 2; i++) begin
            string nm;
            nm = (i == 0) ? "A" : "B";
            chk({nm, ".y"},     (i == 0) ? y_a : y_b, ey[i]);
            chk({nm, ".done"},  (i == 0) ? done_a : done_b, edone[i]);
            chk({nm, ".busy"},  (i == 0) ? busy_a : busy_b, !rst && (!idle[i] || wv[i]));
            chk({nm, ".ready"}, (i == 0) ? bus_a.in_ready : bus_b.in_ready, !rst && en && !wv[i]);
`ifdef ONEHOT_DECODER_PARITY_EN
            chk({nm, ".par_err"}, (i == 0) ? perr_a : perr_b, eperr[i]);
`endif
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    typedef struct {
        bit         en;
        bit         vld;
        logic [2:0] code;
        logic [7:0] y;
        bit         done;
        bit         rdy;
        bit         busy;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t       vt[7];
        logic [2:0] codes3[3];
        logic [7:0] exp_seq[14];
        logic [7:0] seen[$];
        int         k, dones;
        bit         started, stalled;

        rst = 1'b1; en = 1'b0; vld = 1'b0; cd = '0; bad = 1'b0;
        for (int i = 0; i < 2; i++) begin
            left[i] = 0; wv[i] = 1'b0; idle[i] = 1'b1; ey[i] = '0;
            edone[i] = 1'b0; eperr[i] = 1'b0; scode[i] = 0; wcode[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        sample();
        chk("reset.y", y_a, 8'h00);
        chk("reset.busy", busy_a, 1'b0);
        chk("reset.ready", bus_a.in_ready, 1'b0);
        advance();
        rst = 1'b0; en = 1'b1;
        cyc();

        // Single transfer code=5 on A
        vt[0] = '{1, 1, 3'd5, 8'h00, 0, 1, 0};
        vt[1] = '{1, 0, 3'd0, 8'h20, 0, 1, 1};
        vt[2] = '{1, 0, 3'd0, 8'h20, 0, 1, 1};
        vt[3] = '{1, 0, 3'd0, 8'h20, 0, 1, 1};
        vt[4] = '{1, 0, 3'd0, 8'h20, 1, 1, 1};
        vt[5] = '{1, 0, 3'd0, 8'h00, 0, 1, 1};
        vt[6] = '{1, 0, 3'd0, 8'h00, 0, 1, 0};
        for (int v = 0; v < 7; v++) begin
            en = vt[v].en; vld = vt[v].vld; cd = vt[v].code;
            sample();
            chk($sformatf("tbl%0d.y", v), y_a, vt[v].y);
            chk($sformatf("tbl%0d.done", v), done_a, vt[v].done);
            chk($sformatf("tbl%0d.ready", v), bus_a.in_ready, vt[v].rdy);
            chk($sformatf("tbl%0d.busy", v), busy_a, vt[v].busy);
            advance();
        end
        vld = 1'b0;
        repeat (10) cyc();

        // Codes 0,7,3 offered back to back on A
        codes3 = '{3'd0, 3'd7, 3'd3};
        exp_seq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                    8'h80, 8'h80, 8'h80, 8'h80, 8'h00,
                    8'h08, 8'h08, 8'h08, 8'h08};
        k = 0; dones = 0; started = 1'b0; stalled = 1'b0; seen.delete();
        for (int c = 0; c < 40; c++) begin
            vld = (k < 3);
            cd  = codes3[(k < 3) ? k : 0];
            sample();
            if (y_a != 8'h00) started = 1'b1;
            if (started && seen.size() < 14) begin
                seen.push_back(y_a);
                if (done_a) dones++;
            end
            if (vld && !bus_a.in_ready) stalled = 1'b1;
            if (vld && bus_a.in_ready) k++;
            advance();
        end
        vld = 1'b0;
        chk("cont.stall", stalled, 1'b1);
        chk("cont.len", seen.size(), 14);
        for (int j = 0; j < 14; j++)
            chk($sformatf("cont.y%0d", j), (j < seen.size()) ? seen[j] : 8'hxx, exp_seq[j]);
        chk("cont.dones", dones, 3);
        repeat (10) cyc();

        // GAP=0 instance: codes 2 then 6 with no zero cycle between
        codes3 = '{3'd2, 3'd6, 3'd0};
        k = 0; started = 1'b0; seen.delete();
        for (int c = 0; c < 20; c++) begin
            vld = (k < 2);
            cd  = codes3[(k < 2) ? k : 0];
            sample();
            if (y_b != 8'h00) started = 1'b1;
            if (started && seen.size() < 8) seen.push_back(y_b);
            if (vld && bus_b.in_ready) k++;
            advance();
        end
        vld = 1'b0;
        chk("gap0.len", seen.size(), 8);
        for (int j = 0; j < 8; j++)
            chk($sformatf("gap0.y%0d", j), (j < seen.size()) ? seen[j] : 8'hxx,
                (j < 4) ? 8'h04 : 8'h40);
        repeat (10) cyc();

        // en dropped mid-DRIVE with a pending code
        vld = 1'b1; cd = 3'd5; cyc();
        cd = 3'd1; cyc();
        vld = 1'b0; cyc();
        en = 1'b0;
        sample();
        chk("abort.y_before", y_a, 8'h20);
        advance();
        sample();
        chk("abort.y", y_a, 8'h00);
        chk("abort.done", done_a, 1'b0);
        chk("abort.busy", busy_a, 1'b1);
        advance();
        en = 1'b1;
        cyc();
        for (int j = 0; j < 4; j++) begin
            sample();
            chk($sformatf("resume.y%0d", j), y_a, 8'h02);
            chk($sformatf("resume.done%0d", j), done_a, (j == 3));
            advance();
        end
        repeat (10) cyc();

        // rst mid-DRIVE with a pending code
        vld = 1'b1; cd = 3'd4; cyc();
        cd = 3'd6; cyc();
        vld = 1'b0; cyc();
        rst = 1'b1;
        cyc();
        sample();
        chk("rst.y_a", y_a, 8'h00);
        chk("rst.y_b", y_b, 8'h00);
        chk("rst.done", done_a, 1'b0);
        chk("rst.busy", busy_a, 1'b0);
        advance();
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            sample();
            chk($sformatf("postrst.y%0d", j), y_a, 8'h00);
            chk($sformatf("postrst.busy%0d", j), busy_a, 1'b0);
            advance();
        end

`ifdef ONEHOT_DECODER_PARITY_EN
        // Bad parity consumed and dropped, good parity decoded
        vld = 1'b1; cd = 3'd3; bad = 1'b1; cyc();
        vld = 1'b0; bad = 1'b0;
        sample();
        chk("par.err", perr_a, 1'b1);
        chk("par.y_bad", y_a, 8'h00);
        advance();
        for (int j = 0; j < 3; j++) begin
            sample();
            chk($sformatf("par.idle%0d", j), y_a, 8'h00);
            advance();
        end
        vld = 1'b1; cd = 3'd3; cyc();
        vld = 1'b0;
        sample();
        chk("par.y_good", y_a, 8'h08);
        chk("par.noerr", perr_a, 1'b0);
        advance();
        repeat (8) cyc();
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            vld = ($urandom_range(0, 9) < 6);
            cd  = W'($urandom_range(0, 7));
`ifdef ONEHOT_DECODER_PARITY_EN
            bad = ($urandom_range(0, 7) == 0);
`endif
            cyc();
        end
        rst = 1'b0; en = 1'b1; vld = 1'b0; bad = 1'b0;
        repeat (12) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
